// File: rtl/instr_sequencer_pkg.sv
// Shared types and field positions for the instruction sequencer.
// The instruction word is {load, opcode[6:0], cin, data[7:0]}.
package instr_sequencer_pkg;

  localparam int INSTR_W  = 17;
  localparam int DATA_W   = 8;
  localparam int OPC_W    = 7;
  localparam int LOAD_BIT = 16;
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 9;
  localparam int CIN_BIT  = 8;
  localparam int DATA_HI  = 7;
  localparam int DATA_LO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_EXEC,
    ST_CAPTURE,
    ST_RESULT
  } state_t;

  typedef struct packed {
    logic              load;
    logic [OPC_W-1:0]  opcode;
    logic              cin;
    logic [DATA_W-1:0] data;
  } instr_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-in and result-out handshakes of the sequencer.
// The master side produces instructions and consumes results.
interface instr_sequencer_if;
  import instr_sequencer_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               res_valid;
  logic               res_ready;
  logic [DATA_W-1:0]  res_data;
  logic               res_cout;

  modport master (
    output in_valid, in_instr, res_ready,
    input  in_ready, res_valid, res_data, res_cout
  );

  modport slave (
    input  in_valid, in_instr, res_ready,
    output in_ready, res_valid, res_data, res_cout
  );

endinterface

// File: rtl/instr_sequencer_seq_fifo.sv
// Synchronous FIFO with head-of-queue read data; flushing on reset clears
// pointers and count only.
module seq_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Feeds queued instructions to the CPU one at a time and captures the
// accumulator/carry after each ALU op; loads produce no result.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  instr_sequencer_if.slave  bus,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic [OPC_W-1:0]  cpu_opcode,
  output logic              cpu_cin,
  output logic              cpu_load,
  output logic              cpu_ce,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic              cpu_cout,
  output logic              busy
);

  state_t                      state;
  instr_t                      issue_q;
  instr_t                      head;
  logic                        ce_q;
  logic                        res_valid_q;
  logic [DATA_W-1:0]           res_data_q;
  logic                        res_cout_q;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        accept;
  logic                        bypass;
  logic                        fifo_push;
  logic                        fifo_pop;

  // An idle sequencer with nothing queued takes the incoming word directly
  assign accept       = bus.in_valid && bus.in_ready;
  assign fifo_pop     = (state == ST_IDLE) && !fifo_empty;
  assign bypass       = (state == ST_IDLE) && fifo_empty && accept;
  assign fifo_push    = accept && !bypass;
  assign bus.in_ready = rst && !fifo_full;

  seq_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (bus.in_instr),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // issue_q is non-zero only during ISSUE, so it drives the CPU directly
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      issue_q     <= '0;
      ce_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cout_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (fifo_pop || bypass) begin
            issue_q <= fifo_pop ? head : instr_t'(bus.in_instr);
            ce_q    <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          issue_q <= '0;
          ce_q    <= 1'b0;
          state   <= issue_q.load ? ST_IDLE : ST_EXEC;
        end
        ST_EXEC: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          res_data_q  <= cpu_data_out;
          res_cout_q  <= cpu_cout;
          res_valid_q <= 1'b1;
          state       <= ST_RESULT;
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ce        = ce_q;
  assign cpu_load      = issue_q.load;
  assign cpu_opcode    = issue_q.opcode;
  assign cpu_cin       = issue_q.cin;
  assign cpu_data_in   = issue_q.data;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_cout  = res_cout_q;
  assign busy          = (state != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer with a small behavioural CPU:
// ALU ops 0 ADD, 1 ADC (adds cin), 2 AND, 3 XOR; register 0 is the accumulator.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if bus();

  logic [7:0] cpu_data_in;
  logic [7:0] cpu_data_out;
  logic [6:0] cpu_opcode;
  logic       cpu_cin, cpu_load, cpu_ce, cpu_cout, busy;

  instr_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cpu_data_in  (cpu_data_in),
    .cpu_opcode   (cpu_opcode),
    .cpu_cin      (cpu_cin),
    .cpu_load     (cpu_load),
    .cpu_ce       (cpu_ce),
    .cpu_data_out (cpu_data_out),
    .cpu_cout     (cpu_cout),
    .busy         (busy)
  );

  // Behavioural CPU: loads land at the end of ISSUE, ALU ops one cycle later
  logic [7:0] cpu_r [8] = '{default: 8'h00};
  logic       cpu_c = 1'b0;
  logic       pend = 1'b0;
  logic       p_cin = 1'b0;
  logic [6:0] p_op = '0;

  function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic ci);
    case (op)
      4'd0:    alu = {1'b0, a} + {1'b0, b};
      4'd1:    alu = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      4'd2:    alu = {1'b0, a & b};
      4'd3:    alu = {1'b0, a ^ b};
      default: alu = {1'b0, b};
    endcase
  endfunction

  always @(posedge clk) begin
    if (cpu_ce) begin
      if (cpu_load) cpu_r[cpu_opcode[6:4]] <= cpu_data_in;
      else begin
        pend  <= 1'b1;
        p_op  <= cpu_opcode;
        p_cin <= cpu_cin;
      end
    end else if (pend) begin
      pend <= 1'b0;
      {cpu_c, cpu_r[0]} <= alu(p_op[3:0], cpu_r[0], cpu_r[p_op[6:4]], p_cin);
    end
  end

  assign cpu_data_out = cpu_r[0];
  assign cpu_cout     = cpu_c;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  logic [INSTR_W-1:0] exp_issue [$];
  logic [8:0]         exp_res [$];
  int                 ce_log [$];
  int                 cyc = 0;
  int                 ce_cnt = 0;
  int                 res_cnt = 0;
  int                 ce_cyc = -1;
  int                 rv_rise = -1;
  logic               mon_en = 1'b0;
  logic               log_en = 1'b0;
  logic               rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every CPU issue and every accepted result is matched in order
  always @(negedge clk) begin
    if (mon_en) begin
      if (cpu_ce === 1'b1) begin
        ce_cnt++;
        ce_cyc = cyc;
        if (log_en) ce_log.push_back(cyc);
        if (exp_issue.size() == 0)
          flag_fail("issue_unexpected", {cpu_load, cpu_opcode, cpu_cin, cpu_data_in});
        else
          check("issue_order", {cpu_load, cpu_opcode, cpu_cin, cpu_data_in}, exp_issue.pop_front());
      end else begin
        check("cpu_outputs_zero", {cpu_load, cpu_opcode, cpu_cin, cpu_data_in}, 32'd0);
      end
      if (bus.res_valid === 1'b1 && rv_prev !== 1'b1) rv_rise = cyc;
      rv_prev = bus.res_valid;
      if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
        res_cnt++;
        if (exp_res.size() == 0)
          flag_fail("result_unexpected", {bus.res_cout, bus.res_data});
        else
          check("result", {bus.res_cout, bus.res_data}, exp_res.pop_front());
      end
    end
  end

  function automatic logic [INSTR_W-1:0] mk(input logic ld, input logic [6:0] opc,
                                            input logic ci, input logic [7:0] d);
    return {ld, opc, ci, d};
  endfunction

  task automatic push(input logic [INSTR_W-1:0] w, output int t);
    int n;
    n = 0;
    exp_issue.push_back(w);
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) flag_fail("push_timeout", w);
    t = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) flag_fail("idle_timeout", busy);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0, c0, r0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.res_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_res_valid", bus.res_valid, 0);
    check("reset_res_value", {bus.res_cout, bus.res_data}, 0);
    check("reset_busy", busy, 0);
    check("reset_cpu_ce", cpu_ce, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Load r1=0x05, then ADD r1: acc 0x00 + 0x05
    c0 = ce_cnt;
    exp_res.push_back(9'h005);
    push(mk(1'b1, 7'h10, 1'b0, 8'h05), t);
    push(mk(1'b0, 7'h10, 1'b0, 8'h00), t);
    wait_idle();
    check("load_op_ce_pulses", ce_cnt - c0, 2);

    // Latency from an idle, empty sequencer: acc 0x05 + 0x05
    exp_res.push_back(9'h00A);
    push(mk(1'b0, 7'h10, 1'b0, 8'h00), t0);
    wait_idle();
    check("latency_issue_cycle", ce_cyc, t0 + 1);
    check("latency_res_valid_cycle", rv_rise, t0 + 4);

    // Carry: 0xFF + 0x01 -> 0x00/1; ADC 0x00+0x01+1 -> 0x02; XOR 0x3C -> 0x3E
    exp_res.push_back(9'h100);
    exp_res.push_back(9'h002);
    exp_res.push_back(9'h03E);
    push(mk(1'b1, 7'h00, 1'b0, 8'hFF), t);
    push(mk(1'b1, 7'h10, 1'b0, 8'h01), t);
    push(mk(1'b0, 7'h10, 1'b1, 8'h00), t);
    push(mk(1'b0, 7'h11, 1'b1, 8'h00), t);
    push(mk(1'b1, 7'h20, 1'b0, 8'h3C), t);
    push(mk(1'b0, 7'h23, 1'b0, 8'h00), t);
    wait_idle();

    // Stall in RESULT (XOR r1 -> 0x3F), fill FIFO, fifth word held
    bus.res_ready = 1'b0;
    exp_res.push_back(9'h03F);
    exp_res.push_back(9'h083);
    push(mk(1'b0, 7'h13, 1'b0, 8'h00), t);
    repeat (3) @(posedge clk);
    #1;
    check("stall_res_valid_up", bus.res_valid, 1);
    push(mk(1'b1, 7'h30, 1'b0, 8'h11), t);
    push(mk(1'b1, 7'h40, 1'b0, 8'h22), t);
    push(mk(1'b1, 7'h50, 1'b0, 8'h33), t);
    push(mk(1'b1, 7'h60, 1'b0, 8'h44), t);
    check("full_in_ready_low", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_instr = mk(1'b0, 7'h60, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("stall_in_ready_low", bus.in_ready, 0);
    check("stall_res_valid_held", bus.res_valid, 1);
    check("stall_res_data_held", {bus.res_cout, bus.res_data}, 9'h03F);
    bus.res_ready = 1'b1;
    push(mk(1'b0, 7'h60, 1'b0, 8'h00), t);
    wait_idle();

    // Reset during EXEC of ADD r1 (CPU still updates acc to 0x84); queued load flushed
    push(mk(1'b0, 7'h10, 1'b0, 8'h00), t0);
    push(mk(1'b1, 7'h70, 1'b0, 8'h99), t);
    check("reset_point_is_issue_cycle", t, t0 + 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_exec_busy", busy, 0);
    check("rst_exec_res_valid", bus.res_valid, 0);
    check("rst_exec_cpu_ce", cpu_ce, 0);
    check("rst_exec_in_ready", bus.in_ready, 0);
    void'(exp_issue.pop_back());
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_exec_no_result", bus.res_valid, 0);
    check("rst_exec_stays_idle", busy, 0);

    // Stream 10 loads of r1 then ADD r1 with in_valid held high: 0x84 + 0x0A
    log_en = 1'b1;
    c0 = ce_cnt;
    r0 = res_cnt;
    exp_res.push_back(9'h08E);
    for (int i = 0; i < 10; i++) push(mk(1'b1, 7'h10, 1'b0, 8'(i + 1)), t);
    push(mk(1'b0, 7'h10, 1'b0, 8'h00), t);
    wait_idle();
    log_en = 1'b0;
    check("stream_issue_count", ce_cnt - c0, 11);
    for (int i = 1; i < 10; i++)
      check("stream_load_spacing", ce_log[i] - ce_log[i-1], 2);
    check("stream_result_count", res_cnt - r0, 1);

    // r7 must still be zero if the flushed load never issued: 0x8E + 0x00
    exp_res.push_back(9'h08E);
    push(mk(1'b0, 7'h70, 1'b0, 8'h00), t);
    wait_idle();

    check("issue_queue_drained", exp_issue.size(), 0);
    check("result_queue_drained", exp_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, instruction FIFO entries (power of two, >=2).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  in  1  upstream instruction valid.
REQ-005 Port: in_ready  out  1  FIFO can accept a word.
REQ-006 Port: in_instr  in  17  {load[16], opcode[15:9], cin[8], data[7:0]}.
REQ-007 Port: cpu_data_in  out  8  data to CPU data_in.
REQ-008 Port: cpu_opcode  out  7  to CPU opcode ([6:4] register select, [3:0] ALU op).
REQ-009 Port: cpu_cin  out  1  to CPU cin.
REQ-010 Port: cpu_load  out  1  to CPU load.
REQ-011 Port: cpu_ce  out  1  to CPU ce.
REQ-012 Port: cpu_data_out  in  8  CPU accumulator (register 0).
REQ-013 Port: cpu_cout  in  1  CPU carry out.
REQ-014 Port: res_valid  out  1  result available.
REQ-015 Port: res_ready  in  1  downstream accepts result.
REQ-016 Port: res_data  out  8  captured accumulator value.
REQ-017 Port: res_cout  out  1  captured carry.
REQ-018 Port: busy  out  1  high when state != IDLE or FIFO non-empty.

Function
REQ-019 Push: word written when in_valid && in_ready; in_ready = !full (no same-cycle pop bypass when full).
REQ-020 FSM states: IDLE, ISSUE, EXEC, CAPTURE, RESULT.
REQ-021 IDLE: if FIFO non-empty, pop head into issue register, go ISSUE; else stay IDLE.
REQ-022 ISSUE (1 cycle): cpu_ce=1, cpu_load/opcode/cin/data_in from issue register; next EXEC if load=0, IDLE if load=1.
REQ-023 EXEC (1 cycle): cpu_ce=0; CPU writes accumulator and carry at end of cycle; next CAPTURE.
REQ-024 CAPTURE (1 cycle): res_data<=cpu_data_out, res_cout<=cpu_cout at cycle end; next RESULT.
REQ-025 RESULT: res_valid=1, res_data/res_cout stable; on res_ready go IDLE; no pop while in RESULT.
REQ-026 All cpu_* outputs 0 in every state except ISSUE.
REQ-027 Latency: op word pushed in cycle 0 into empty FIFO with idle FSM -> ISSUE cycle 1, EXEC 2, CAPTURE 3, res_valid high from cycle 4.
REQ-028 Load throughput: back-to-back loads issue every 2 cycles (ISSUE, IDLE); no result produced for loads.
REQ-029 Instructions issued strictly in FIFO order; FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-030 Simultaneous push and pop when neither full nor empty: count unchanged, both take effect.
REQ-031 res_valid held while res_ready=0 indefinitely; FIFO keeps accepting until full.

Reset
REQ-032 On rst=0 at clock edge: state=IDLE, FIFO pointers/count=0 (contents flushed), issue register=0.
REQ-033 Reset values: in_ready=0 during reset then 1, cpu_*=0, res_valid=0, res_data=0, res_cout=0, busy=0.
REQ-034 Reset mid-operation (any state) aborts instruction; no result emitted; CPU reset is separate.

Structure
REQ-035 Shared package: state enum, instruction field bit positions, INSTR_W=17 constant.
REQ-036 One sub-module: seq_fifo (synchronous FIFO, parameterised width/depth, full/empty/count).

Verification
REQ-037 Load 0x05 to r1 then op opcode 0x10|ADD: cpu_ce pulses twice, res_valid with ALU result per CPU op table at cycle 4 after op reaches head.
REQ-038 Push 5 words with FIFO_DEPTH=4, sequencer stalled in RESULT (res_ready=0): in_ready low after 4th, 5th held, accepted after res_ready.
REQ-039 Op with cin=1 producing carry (acc 0xFF + r1 0x01): res_data=0x00, res_cout=1.
REQ-040 Assert rst=0 during EXEC: next cycle state IDLE, res_valid=0, cpu_ce=0, FIFO empty, busy=0.
REQ-041 Stream 10 loads then 1 op with in_valid always high: order preserved, loads 2 cycles apart, pointers wrap, exactly one result.
